// File: rtl/mat_regfile_stream.sv
// Matrix register bank with direct row/matrix writes, same-cycle forwarding,
// and row-by-row load/store streaming engines over valid/ready.

module mat_regfile_row #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld_we,
  input  logic [XLEN-1:0] ld_data,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_data,
  output logic [XLEN-1:0] fwd
);
  logic [XLEN-1:0] q;

  // Load beat has priority over a direct write to the same row.
  assign fwd = ld_we ? ld_data : (d_we ? d_data : q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                q <= '0;
    else if (ld_we || d_we)  q <= fwd;
  end
endmodule

module mat_regfile_stream #(
  parameter int XLEN    = 32,
  parameter int ROWS    = 4,
  parameter int NUM_MAT = 4,
  localparam int MW = (NUM_MAT > 2) ? $clog2(NUM_MAT) : 1,
  localparam int RW = (ROWS > 2) ? $clog2(ROWS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [MW-1:0]        r_mat_sel,
  input  logic [RW-1:0]        r_row_sel,
  output logic [XLEN-1:0]      r_row_o,
  output logic [ROWS*XLEN-1:0] r_mat_o,
  output logic                 r_stall_o,
  input  logic [1:0]           w_select,
  input  logic [MW-1:0]        w_mat_sel,
  input  logic [RW-1:0]        w_row_sel,
  input  logic [XLEN-1:0]      w_row_data,
  input  logic [ROWS*XLEN-1:0] w_mat_data,
  input  logic                 ld_start,
  input  logic [MW-1:0]        ld_mat_sel,
  input  logic                 ld_valid,
  input  logic [XLEN-1:0]      ld_data,
  output logic                 ld_ready_o,
  output logic                 ld_busy_o,
  output logic                 ld_done_o,
  input  logic                 st_start,
  input  logic [MW-1:0]        st_mat_sel,
  output logic                 st_valid_o,
  output logic [XLEN-1:0]      st_data_o,
  output logic                 st_last_o,
  input  logic                 st_ready,
  output logic                 st_busy_o
);
  typedef enum logic {LD_IDLE, LD_LOAD} ld_state_t;
  typedef enum logic {ST_IDLE, ST_SEND} st_state_t;

  ld_state_t ld_state, ld_nxt;
  st_state_t st_state, st_nxt;

  logic [MW-1:0]   ld_mat, st_mat;
  logic [RW-1:0]   ld_cnt, st_cnt;
  logic            ld_beat, ld_last, st_go, st_hs, st_end;
  logic [NUM_MAT-1:0][ROWS-1:0][XLEN-1:0] fwd;

  assign ld_busy_o  = (ld_state == LD_LOAD);
  assign ld_ready_o = ld_busy_o;
  assign ld_beat    = ld_valid && ld_ready_o;
  assign ld_last    = (ld_cnt == RW'(ROWS-1));
  assign r_stall_o  = ld_busy_o && (r_mat_sel == ld_mat);

  assign st_busy_o  = (st_state == ST_SEND);
  assign st_valid_o = st_busy_o;
  assign st_hs      = st_valid_o && st_ready;
  assign st_end     = (st_cnt == RW'(ROWS-1));
  // A store of the matrix currently being loaded would read stale rows.
  assign st_go      = (st_state == ST_IDLE) && st_start &&
                      !(ld_busy_o && (st_mat_sel == ld_mat));

  for (genvar m = 0; m < NUM_MAT; m++) begin : g_mat
    for (genvar r = 0; r < ROWS; r++) begin : g_row
      logic            ld_we, d_we;
      logic [XLEN-1:0] d_data;
      assign ld_we  = ld_beat && (ld_mat == MW'(m)) && (ld_cnt == RW'(r));
      assign d_we   = (w_mat_sel == MW'(m)) &&
                      ((w_select == 2'b11) || ((w_select == 2'b10) && (w_row_sel == RW'(r))));
      assign d_data = w_select[0] ? w_mat_data[r*XLEN +: XLEN] : w_row_data;
      mat_regfile_row #(.XLEN(XLEN)) u_row (
        .clk(clk), .rst(rst), .ld_we(ld_we), .ld_data(ld_data),
        .d_we(d_we), .d_data(d_data), .fwd(fwd[m][r])
      );
    end
  end

  assign r_mat_o = fwd[r_mat_sel];
  assign r_row_o = fwd[r_mat_sel][r_row_sel];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_state <= LD_IDLE;
      st_state <= ST_IDLE;
    end else begin
      ld_state <= ld_nxt;
      st_state <= st_nxt;
    end
  end

  always_comb begin
    ld_nxt = ld_state;
    st_nxt = st_state;
    case (ld_state)
      LD_IDLE: if (ld_start) ld_nxt = LD_LOAD;
      LD_LOAD: if (ld_beat && ld_last) ld_nxt = LD_IDLE;
      default: ld_nxt = LD_IDLE;
    endcase
    case (st_state)
      ST_IDLE: if (st_go) st_nxt = ST_SEND;
      ST_SEND: if (st_hs && st_end) st_nxt = ST_IDLE;
      default: st_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_mat    <= '0;
      ld_cnt    <= '0;
      ld_done_o <= 1'b0;
      st_mat    <= '0;
      st_cnt    <= '0;
      st_data_o <= '0;
      st_last_o <= 1'b0;
    end else begin
      ld_done_o <= ld_beat && ld_last;
      if ((ld_state == LD_IDLE) && ld_start) begin
        ld_mat <= ld_mat_sel;
        ld_cnt <= '0;
      end else if (ld_beat) begin
        ld_cnt <= ld_last ? '0 : ld_cnt + RW'(1);
      end
      if (st_go) begin
        st_mat    <= st_mat_sel;
        st_cnt    <= '0;
        st_data_o <= fwd[st_mat_sel][0];
        st_last_o <= 1'b0;
      end else if (st_hs) begin
        if (st_end) begin
          st_cnt    <= '0;
          st_data_o <= '0;
          st_last_o <= 1'b0;
        end else begin
          // Capture the forwarded row so a same-cycle write is not missed.
          st_cnt    <= st_cnt + RW'(1);
          st_data_o <= fwd[st_mat][st_cnt + RW'(1)];
          st_last_o <= ((st_cnt + RW'(1)) == RW'(ROWS-1));
        end
      end
    end
  end
endmodule

// File: tb/tb_mat_regfile_stream.sv
// Directed bench for mat_regfile_stream: writes, forwarding, load/store
// streaming, collisions, stall/ignore rules and mid-stream reset.

module tb_mat_regfile_stream;
  localparam int XLEN = 32, ROWS = 4, NUM_MAT = 4, MW = 2, RW = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [MW-1:0]        r_mat_sel;
  logic [RW-1:0]        r_row_sel;
  logic [XLEN-1:0]      r_row_o;
  logic [ROWS*XLEN-1:0] r_mat_o;
  logic                 r_stall_o;
  logic [1:0]           w_select;
  logic [MW-1:0]        w_mat_sel;
  logic [RW-1:0]        w_row_sel;
  logic [XLEN-1:0]      w_row_data;
  logic [ROWS*XLEN-1:0] w_mat_data;
  logic                 ld_start, ld_valid, ld_ready_o, ld_busy_o, ld_done_o;
  logic [MW-1:0]        ld_mat_sel;
  logic [XLEN-1:0]      ld_data;
  logic                 st_start, st_valid_o, st_last_o, st_ready, st_busy_o;
  logic [MW-1:0]        st_mat_sel;
  logic [XLEN-1:0]      st_data_o;

  int checks = 0;
  int failures = 0;
  int hs_cnt = 0;

  always #5 clk = ~clk;

  mat_regfile_stream #(.XLEN(XLEN), .ROWS(ROWS), .NUM_MAT(NUM_MAT)) dut (
    .clk(clk), .rst(rst),
    .r_mat_sel(r_mat_sel), .r_row_sel(r_row_sel), .r_row_o(r_row_o),
    .r_mat_o(r_mat_o), .r_stall_o(r_stall_o),
    .w_select(w_select), .w_mat_sel(w_mat_sel), .w_row_sel(w_row_sel),
    .w_row_data(w_row_data), .w_mat_data(w_mat_data),
    .ld_start(ld_start), .ld_mat_sel(ld_mat_sel), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_ready_o(ld_ready_o), .ld_busy_o(ld_busy_o),
    .ld_done_o(ld_done_o),
    .st_start(st_start), .st_mat_sel(st_mat_sel), .st_valid_o(st_valid_o),
    .st_data_o(st_data_o), .st_last_o(st_last_o), .st_ready(st_ready),
    .st_busy_o(st_busy_o)
  );

  always @(posedge clk) if (rst && st_valid_o && st_ready) hs_cnt <= hs_cnt + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, " ld_ready"}, ld_ready_o, 0);
    chk({tag, " ld_busy"},  ld_busy_o, 0);
    chk({tag, " ld_done"},  ld_done_o, 0);
    chk({tag, " st_valid"}, st_valid_o, 0);
    chk({tag, " st_data"},  st_data_o, 0);
    chk({tag, " st_last"},  st_last_o, 0);
    chk({tag, " st_busy"},  st_busy_o, 0);
    chk({tag, " r_stall"},  r_stall_o, 0);
  endtask

  initial begin
    rst = 1'b0;
    r_mat_sel = '0; r_row_sel = '0;
    w_select = '0; w_mat_sel = '0; w_row_sel = '0; w_row_data = '0; w_mat_data = '0;
    ld_start = 0; ld_mat_sel = '0; ld_valid = 0; ld_data = '0;
    st_start = 0; st_mat_sel = '0; st_ready = 0;
    #3;
    chk_idle_outs("reset");
    chk("reset r_mat", r_mat_o, 0);
    tick();
    rst = 1'b1;
    for (int m = 0; m < NUM_MAT; m++) begin
      r_mat_sel = MW'(m);
      #1 chk($sformatf("init M%0d", m), r_mat_o, 0);
    end

    // Mode-10 single-row write with same-cycle read
    w_select = 2'b10; w_mat_sel = 2; w_row_sel = 1; w_row_data = 32'hDEADBEEF;
    r_mat_sel = 2; r_row_sel = 1;
    #1 chk("w10 fwd", r_row_o, 32'hDEADBEEF);
    chk("w10 stall", r_stall_o, 0);
    tick(); w_select = 2'b00;
    #1 chk("w10 file", r_row_o, 32'hDEADBEEF);
    chk("w10 other rows", r_mat_o, 128'h00000000_00000000_DEADBEEF_00000000);

    // Mode-11 whole-matrix write
    w_select = 2'b11; w_mat_sel = 1;
    w_mat_data = 128'h00000004_00000003_00000002_00000001;
    r_mat_sel = 1;
    #1 chk("w11 fwd", r_mat_o, 128'h00000004_00000003_00000002_00000001);
    tick(); w_select = 2'b00; w_mat_data = '0;
    #1 chk("w11 file", r_mat_o, 128'h00000004_00000003_00000002_00000001);

    // Load M3 with a gap after beat 2
    ld_start = 1; ld_mat_sel = 3;
    tick(); ld_start = 0; r_mat_sel = 3;
    #1 chk("ld ready", ld_ready_o, 1);
    chk("ld busy", ld_busy_o, 1);
    chk("ld stall", r_stall_o, 1);
    ld_valid = 1; ld_data = 32'h11; r_row_sel = 0;
    #1 chk("ld beat0 fwd", r_row_o, 32'h11);
    tick(); ld_data = 32'h22;
    tick(); ld_valid = 0;
    #1 chk("ld gap stall", r_stall_o, 1);
    tick();
    #1 chk("ld gap2 stall", r_stall_o, 1);
    tick(); ld_valid = 1; ld_data = 32'h33;
    tick(); ld_data = 32'h44; r_row_sel = 3;
    #1 chk("ld beat3 fwd", r_row_o, 32'h44);
    chk("ld last stall", r_stall_o, 1);
    tick(); ld_valid = 0;
    #1 chk("ld done", ld_done_o, 1);
    chk("ld busy after", ld_busy_o, 0);
    chk("ld stall after", r_stall_o, 0);
    tick();
    #1 chk("ld done pulse", ld_done_o, 0);
    chk("ld M3", r_mat_o, 128'h00000044_00000033_00000022_00000011);

    // Store M3 with back-pressure on row 1
    st_start = 1; st_mat_sel = 3;
    tick(); st_start = 0;
    #1 chk("st valid", st_valid_o, 1);
    chk("st row0", st_data_o, 32'h11);
    chk("st busy", st_busy_o, 1);
    st_ready = 1;
    tick(); st_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("st hold%0d", i), st_data_o, 32'h22);
      chk($sformatf("st hold last%0d", i), st_last_o, 0);
      chk($sformatf("st hold valid%0d", i), st_valid_o, 1);
      tick();
    end
    st_ready = 1;
    tick();
    #1 chk("st row2", st_data_o, 32'h33);
    chk("st row2 last", st_last_o, 0);
    tick();
    #1 chk("st row3", st_data_o, 32'h44);
    chk("st row3 last", st_last_o, 1);
    tick(); st_ready = 0;
    #1 chk("st end valid", st_valid_o, 0);
    chk("st end data", st_data_o, 0);
    chk("st end busy", st_busy_o, 0);
    chk("st handshakes", hs_cnt, 4);

    // Collision on M0 row0, store of loading matrix ignored
    ld_start = 1; ld_mat_sel = 0;
    tick(); ld_start = 0;
    ld_valid = 1; ld_data = 32'hAAAA;
    w_select = 2'b10; w_mat_sel = 0; w_row_sel = 0; w_row_data = 32'hBBBB;
    st_start = 1; st_mat_sel = 0;
    r_mat_sel = 0; r_row_sel = 0;
    #1 chk("coll fwd", r_row_o, 32'hAAAA);
    tick(); w_select = 2'b00; st_start = 0;
    #1 chk("coll file", r_row_o, 32'hAAAA);
    chk("st ignored busy", st_busy_o, 0);
    chk("st ignored valid", st_valid_o, 0);
    ld_data = 32'h1111;
    w_select = 2'b11; w_mat_sel = 0;
    w_mat_data = 128'h0000000D_0000000C_0000000B_0000000A;
    #1 chk("coll w11 fwd", r_mat_o, 128'h0000000D_0000000C_00001111_0000000A);
    tick(); w_select = 2'b00; ld_data = 32'h2222;
    tick(); ld_data = 32'h3333;
    tick(); ld_valid = 0;
    #1 chk("coll M0", r_mat_o, 128'h00003333_00002222_00001111_0000000A);
    chk("coll done", ld_done_o, 1);
    tick();

    // Mid-stream reset: load M2 and store M1 concurrently
    ld_start = 1; ld_mat_sel = 2; st_start = 1; st_mat_sel = 1;
    tick(); ld_start = 0; st_start = 0;
    #1 chk("conc st row0", st_data_o, 32'h1);
    ld_valid = 1; ld_data = 32'h55; st_ready = 1;
    tick(); ld_data = 32'h66; st_ready = 0;
    tick();
    #1 chk("conc st row1", st_data_o, 32'h2);
    r_mat_sel = 2;
    rst = 1'b0;
    #1;
    chk_idle_outs("midrst");
    chk("midrst r_mat", r_mat_o, 0);
    ld_valid = 0;
    #2 rst = 1'b1;
    tick();
    for (int m = 0; m < NUM_MAT; m++) begin
      r_mat_sel = MW'(m);
      #1 chk($sformatf("post rst M%0d", m), r_mat_o, 0);
    end
    chk_idle_outs("post rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
